ahb_slave_mem: RTL
==================

// Module: ahb_slave_mem
// PURPOSE
//  AHB-Lite responder at the far end of the address decoder: one instance sits behind each HSELx.
//  Small word-organised register memory with programmable wait states and ERROR response.
//  Consumes decoded HSEL plus the shared address/control bus.
//  Returns HRDATA/HREADYOUT/HRESP to the response mux.
// PARAMETERS
//  ADDR_W       5   local byte-address bits used (HADDR[ADDR_W-1:0]); DEPTH = 2**(ADDR_W-2) words
//  WAIT_STATES  1   HREADYOUT-low cycles per OKAY data phase, 0..15
// PORTS
//  HCLK       in   1   clock, all state on rising edge
//  HRESETn    in   1   reset, ASYNCHRONOUS, ACTIVE-HIGH (1 = in reset; the name is kept as-is)
//  HSEL       in   1   select from decoder
//  HADDR      in   32  byte address; only [ADDR_W-1:0] used
//  HTRANS     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HWRITE     in   1   1 = write
//  HSIZE      in   3   000 byte, 001 half, 010 word; others illegal
//  HWDATA     in   32  write data, valid in data phase
//  HREADYIN   in   1   bus-level HREADY (previous transfer completing)
//  HRDATA     out  32  read data
//  HREADYOUT  out  1   this slave's ready
//  HRESP      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, memory cleared to 0.
//  Accept: address phase is valid when HSEL & HTRANS[1] & HREADYIN at a rising edge.
//    On acceptance, register addr, HWRITE, HSIZE. IDLE/BUSY or HSEL=0 -> no access.
//    These give a zero-wait OKAY response (HREADYOUT=1, HRESP=0).
//  Legality: HSIZE>2, or a misaligned address (half: HADDR[0]=1; word: HADDR[1:0]!=0), is illegal.
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//    IDLE --legal accept, WAIT_STATES>0--> WAIT. Counter loaded with WAIT_STATES-1. HREADYOUT=0.
//    IDLE --legal accept, WAIT_STATES=0--> IDLE. Data phase completes the next cycle with HREADYOUT=1.
//    WAIT: decrement the counter. When it reaches 0, the next cycle drives HREADYOUT=1 (completion).
//    IDLE --illegal accept--> ERR1: HRESP=1, HREADYOUT=0. Then ERR2: HRESP=1, HREADYOUT=1. Then IDLE.
//    Illegal transfers never modify memory.
//  Completion cycle (HREADYOUT=1, OKAY):
//    Write: HWDATA byte lanes are committed at the edge that ends the cycle.
//    Lanes are selected from HSIZE and addr[1:0] (little-endian).
//    Read: HRDATA = mem[addr[ADDR_W-1:2]] (full word; the master selects lanes).
//    HRDATA = 0 in every cycle that is not a read completion.
//  Pipelining:
//    A new address phase may be accepted in the same cycle that the current data phase completes.
//    Back-to-back transfers then have no idle gap.
//    Read after write to the same word sees the new data.
//    During WAIT/ERR1, HREADYIN=0, so no new acceptance can occur.
//  BUSY or IDLE arriving mid-burst: no new data phase. An outstanding data phase still completes normally.
//  Reset mid-transfer: immediate return to the reset state. A pending write is dropped. Memory is cleared.
//  Address aliasing: HADDR bits >= ADDR_W are ignored; the index wraps within DEPTH.
// STRUCTURE
//  Shared package ahb_pkg:
//    HTRANS_IDLE/BUSY/NONSEQ/SEQ, HSIZE_BYTE/HALF/WORD, HRESP_OKAY/ERROR.
//    FSM state encoding for ahb_slave_mem.
//  Sub-module ahb_lane_strobe (combinational):
//    inputs HSIZE and addr[1:0] -> 4-bit byte-lane enable plus illegal flag.
//    Reused by later APB bridge.
// TESTING
//  1. Reset high mid-WAIT -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; read of word 0 returns 0.
//  2. WAIT_STATES=1. NONSEQ word write 0xDEADBEEF @0x08 -> 1 cycle HREADYOUT=0, then commit.
//     Read @0x08 -> 1 wait, then HRDATA=0xDEADBEEF.
//  3. Byte write 0xAA @0x0D onto word 0x11223344 @0x0C -> read returns 0x1122AA44.
//  4. WAIT_STATES=0. Pipelined NONSEQ,SEQ,SEQ writes @0x00,0x04,0x08 then reads -> HREADYOUT always 1.
//     Data matches. The read immediately after the final write returns the new value.
//  5. HSIZE=011, or a word write @0x02 -> HRESP=1 for 2 cycles (HREADYOUT 0 then 1). Memory unchanged.
//  6. HTRANS=IDLE with HSEL=1, or HSEL=0 with NONSEQ -> HREADYOUT=1, HRESP=0, memory unchanged.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and the ahb_slave_mem FSM state type
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} ahb_state_e;
endpackage

// File: rtl/ahb_lane_strobe.sv
// ahb_lane_strobe: HSIZE + addr[1:0] -> little-endian byte-lane enables and illegal flag
module ahb_lane_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o,
  output logic       illegal_o
);
  always_comb begin
    strb_o = size_i == HSIZE_BYTE ? 4'b0001 << addr_i :
             size_i == HSIZE_HALF ? (addr_i[1] ? 4'b1100 : 4'b0011) :
             size_i == HSIZE_WORD ? 4'b1111 : 4'b0000;
    illegal_o = size_i > HSIZE_WORD || (size_i == HSIZE_HALF && addr_i[0]) ||
                (size_i == HSIZE_WORD && addr_i != 2'b00);
  end
endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite word memory slave with programmable wait states and two-cycle ERROR
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYIN,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  localparam int IW = ADDR_W - 2;
  localparam int DEPTH = 2 ** IW;
  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);
  ahb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, strb, strb_q;
  logic [IW-1:0] idx_q;
  logic [31:0] mem_q [DEPTH];
  logic write_q, act_q, act_d, illegal, ready, accept, done, unused;
  ahb_lane_strobe u_lane (
    .size_i(HSIZE),
    .addr_i(HADDR[1:0]),
    .strb_o(strb),
    .illegal_o(illegal)
  );
  assign unused = ^{HADDR[31:ADDR_W], HTRANS[0]};
  assign ready = state_q != ST_WAIT && state_q != ST_ERR1;
  assign accept = HSEL & HTRANS[1] & HREADYIN & ready;
  assign done = act_q & ready;
  assign HREADYOUT = ready;
  assign HRESP = state_q == ST_ERR1 || state_q == ST_ERR2 ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA = done && !write_q ? mem_q[idx_q] : '0;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == ST_WAIT) begin
      state_d = cnt_q == 4'd0 ? ST_IDLE : ST_WAIT;
      cnt_d = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else begin
      state_d = !accept ? ST_IDLE : illegal ? ST_ERR1 : WAIT_STATES > 0 ? ST_WAIT : ST_IDLE;
      cnt_d = state_d == ST_WAIT ? WS_M1 : 4'd0;
    end
    // act tracks a legal data phase still owed a completion cycle
    act_d = accept ? !illegal : ready ? 1'b0 : act_q;
  end
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      act_q <= 1'b0;
      idx_q <= '0;
      write_q <= 1'b0;
      strb_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      if (accept) begin
        idx_q <= HADDR[ADDR_W-1:2];
        write_q <= HWRITE;
        strb_q <= strb;
      end
      if (done && write_q)
        for (int b = 0; b < 4; b++)
          if (strb_q[b]) mem_q[idx_q][8*b+:8] <= HWDATA[8*b+:8];
    end
  end
endmodule
